// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// The optional round-robin tie-break is enabled with `define MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam int   CNT_W     = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner selection between fetch and data requesters.
// `define MEM_ARB_RR_EN selects alternating tie-break; otherwise data wins ties.
import mem_arb_pkg::*;

module mem_arb_grant (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = i_req | d_req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_owner = OWN_FETCH;
    if (i_req && d_req)
      grant_owner = (last_grant == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    else if (d_req)
      grant_owner = OWN_DATA;
  end
`else
  // last_grant has no role under fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_owner = d_req ? OWN_DATA : OWN_FETCH;
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-requester arbiter in front of a single-ported 16-bit memory with LATENCY wait states.
// Tie-break policy is chosen in mem_arb_grant via `define MEM_ARB_RR_EN.
import mem_arb_pkg::*;

module mem_req_arbiter #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_stall,
  output logic        i_done,
  output logic        i_err,
  output logic [15:0] i_rdata,
  output logic        d_stall,
  output logic        d_done,
  output logic        d_err,
  output logic [15:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               own, own_nxt;
  logic               lat_wr, wr_nxt;
  logic [15:0]        lat_addr, addr_nxt;
  logic [15:0]        lat_wdata, wdata_nxt;
  logic               last_grant, last_nxt;
  logic               grant_valid, grant_owner;
  logic               go_nxt, fin_nxt;

  mem_arb_grant u_grant (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    own_nxt   = own;
    wr_nxt    = lat_wr;
    addr_nxt  = lat_addr;
    wdata_nxt = lat_wdata;
    last_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          own_nxt   = grant_owner;
          last_nxt  = grant_owner;
          wr_nxt    = (grant_owner == OWN_DATA) ? d_wr : 1'b0;
          addr_nxt  = (grant_owner == OWN_DATA) ? d_addr : i_addr;
          wdata_nxt = d_wdata;
          // misaligned requests complete immediately with an error, no access
          if (addr_nxt[0]) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else           state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // memory strobes are registered, so they are set on entry to the final BUSY cycle
    go_nxt  = (state_nxt == BUSY) && (cnt_nxt == '0);
    fin_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      own        <= OWN_FETCH;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      last_grant <= OWN_FETCH;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_done     <= 1'b0;
      i_err      <= 1'b0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      own        <= own_nxt;
      lat_wr     <= wr_nxt;
      lat_addr   <= addr_nxt;
      lat_wdata  <= wdata_nxt;
      last_grant <= last_nxt;
      mem_enable <= go_nxt;
      mem_wr     <= go_nxt & wr_nxt;
      mem_addr   <= go_nxt ? addr_nxt  : '0;
      mem_wdata  <= go_nxt ? wdata_nxt : '0;
      i_done     <= fin_nxt && (own_nxt == OWN_FETCH);
      i_err      <= fin_nxt && (own_nxt == OWN_FETCH) && addr_nxt[0];
      d_done     <= fin_nxt && (own_nxt == OWN_DATA);
      d_err      <= fin_nxt && (own_nxt == OWN_DATA) && addr_nxt[0];
      if ((state == BUSY) && (cnt == '0) && !lat_wr) begin
        if (own == OWN_DATA) d_rdata <= mem_rdata;
        else                 i_rdata <= mem_rdata;
      end
    end
  end

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a 256-byte big-endian memory model.
// Tie-break expectations follow `define MEM_ARB_RR_EN when it is set.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_stall, i_done, i_err, d_stall, d_done, d_err;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:255] = '{default: 8'h00};
  logic [7:0]  unused_hi;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_stall(i_stall), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
    .d_stall(d_stall), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_enable && mem_wr) begin
      mem[mem_addr[7:0]]         <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[7:0];
    end
  end
  assign mem_rdata = {mem[mem_addr[7:0]], mem[mem_addr[7:0] + 8'd1]};
  assign unused_hi = mem_addr[15:8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_cyc;
    bit          exp_err;
    logic [15:0] exp_rdata;
    int          exp_en;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0, en_cnt = 0, en_cyc = -1, other = 0;
    bit got = 0, wr_seen = 0;
    @(negedge clk);
    if (v.is_data) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    chk({tag, " stall0"}, v.is_data ? d_stall : i_stall, 1);
    while (!got && cyc < 20) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (mem_enable) begin en_cnt++; en_cyc = cyc; wr_seen = mem_wr; end
      if (v.is_data ? i_done : d_done) other++;
      if (v.is_data ? d_done : i_done) begin
        got = 1;
        chk({tag, " err"},   v.is_data ? d_err : i_err, v.exp_err);
        chk({tag, " rdata"}, v.is_data ? d_rdata : i_rdata, v.exp_rdata);
        if (v.wr && !v.exp_err)
          chk({tag, " membytes"}, {mem[v.addr[7:0]], mem[v.addr[7:0] + 8'd1]}, v.wdata);
      end
    end
    chk({tag, " done_cycle"}, cyc, v.exp_cyc);
    chk({tag, " en_count"}, en_cnt, v.exp_en);
    if (v.exp_en != 0) begin
      chk({tag, " en_cycle"}, en_cyc, v.exp_cyc - 1);
      chk({tag, " mem_wr"}, wr_seen, v.wr);
    end
    chk({tag, " other_done"}, other, 0);
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    int cyc, first_cyc, second_cyc, i_cnt, stall_bad, i_d1, i_d2;
    bit first_is_data;
    logic [15:0] r1;

    vecs[0]  = '{1, 1, 16'h0010, 16'hBEEF, 5, 0, 16'h0000, 1};
    vecs[1]  = '{1, 0, 16'h0010, 16'h0000, 5, 0, 16'hBEEF, 1};
    vecs[2]  = '{1, 0, 16'h0011, 16'h0000, 1, 1, 16'hBEEF, 0};
    vecs[3]  = '{0, 0, 16'h0010, 16'h0000, 5, 0, 16'hBEEF, 1};
    vecs[4]  = '{1, 1, 16'h0030, 16'h1357, 5, 0, 16'hBEEF, 1};
    vecs[5]  = '{0, 0, 16'h0030, 16'h0000, 5, 0, 16'h1357, 1};
    vecs[6]  = '{0, 0, 16'h0003, 16'h0000, 1, 1, 16'h1357, 0};
    vecs[7]  = '{1, 1, 16'h0000, 16'h1122, 5, 0, 16'hBEEF, 1};
    vecs[8]  = '{1, 1, 16'h0002, 16'h3344, 5, 0, 16'hBEEF, 1};
    vecs[9]  = '{1, 1, 16'h00FE, 16'hA5C3, 5, 0, 16'hBEEF, 1};
    vecs[10] = '{1, 0, 16'h00FE, 16'h0000, 5, 0, 16'hA5C3, 1};

    i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    rst = 1'b1;
    #1;
    chk("reset outs", {i_done, i_err, d_done, d_err, mem_enable, mem_wr, i_stall, d_stall}, 0);
    chk("reset rdata", {i_rdata, d_rdata}, 0);
    chk("reset mem_bus", {mem_addr, mem_wdata}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // tie: last grant was DATA
    @(negedge clk);
    i_req = 1; i_addr = 16'h0010; d_req = 1; d_wr = 0; d_addr = 16'h0030;
    cyc = 0; first_cyc = -1; second_cyc = -1; stall_bad = 0; first_is_data = 0;
    while (second_cyc < 0 && cyc < 30) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (d_done || i_done) begin
        if (first_cyc < 0) begin
          first_cyc = cyc; first_is_data = d_done;
          r1 = d_done ? d_rdata : i_rdata;
        end else begin
          second_cyc = cyc;
        end
        if (d_done) d_req = 0;
        if (i_done) i_req = 0;
      end else if (first_cyc >= 0) begin
        if (first_is_data ? !i_stall : !d_stall) stall_bad++;
      end else if (!i_stall || !d_stall) begin
        stall_bad++;
      end
    end
`ifdef MEM_ARB_RR_EN
    chk("tie winner", first_is_data, 0);
    chk("tie first rdata", r1, 16'hBEEF);
    chk("tie second rdata", d_rdata, 16'h1357);
`else
    chk("tie winner", first_is_data, 1);
    chk("tie first rdata", r1, 16'h1357);
    chk("tie second rdata", i_rdata, 16'hBEEF);
`endif
    chk("tie first cycle", first_cyc, 5);
    chk("tie second cycle", second_cyc, 11);
    chk("tie loser stall", stall_bad, 0);
    i_req = 0; d_req = 0;

    // reset while the write strobe is up
    @(negedge clk);
    d_req = 1; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    chk("rst pre mem_enable", mem_enable, 1);
    rst = 1'b1; d_req = 0; d_wr = 0;
    #1;
    chk("rst abort outs", {mem_enable, mem_wr, d_done, d_err, i_done}, 0);
    chk("rst abort rdata", d_rdata, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst no write", {mem[8'h20], mem[8'h21]}, 0);
    run_vec('{1, 0, 16'h0010, 16'h0000, 5, 0, 16'hBEEF, 1}, "post_rst");

    // back-to-back fetches with i_req held
    @(negedge clk);
    i_req = 1; i_addr = 16'h0000;
    cyc = 0; i_cnt = 0; i_d1 = -1; i_d2 = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); @(negedge clk);
      if (i_done) begin
        i_cnt++;
        if (i_cnt == 1) begin
          i_d1 = c; chk("b2b rdata0", i_rdata, 16'h1122); i_addr = 16'h0002;
        end else begin
          i_d2 = c; chk("b2b rdata1", i_rdata, 16'h3344);
        end
      end
    end
    i_req = 0;
    chk("b2b done count", i_cnt, 2);
    chk("b2b first done", i_d1, 5);
    chk("b2b second done", i_d2, 11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
